// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg: shared definitions for the ROM read arbiter.
//   - Default ROM geometry (address width, word width, depth).
//   - FSM state encoding used by rom_read_arbiter.
package rom_arb_pkg;

    // Default geometry of the shared ROM (8 entries x 8 bits).
    localparam int unsigned ROM_ADDR_W = 3;
    localparam int unsigned ROM_DATA_W = 8;
    localparam int unsigned ROM_DEPTH  = 2 ** ROM_ADDR_W;

    // IDLE: arbitrating between requesters.
    // BURST: stepping through consecutive ROM addresses for the owner.
    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//
// Search order starts at last_grant+1 and wraps, so the most recently served
// requester has the lowest priority on the next pick.
//
// Ports:
//   req        in  NUM_REQ  pending requests
//   last_grant in  ID_W     index granted most recently
//   grant      out NUM_REQ  one-hot grant (all-zero when no request)
//   grant_idx  out ID_W     encoded index of grant (0 when no request)
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    int unsigned idx;
    logic        found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        // Offsets 1..NUM_REQ visit every requester once, ending on last_grant.
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            idx = (32'(last_grant) + off) % NUM_REQ;
            if (!found && req[ID_W'(idx)]) begin
                grant[ID_W'(idx)] = 1'b1;
                grant_idx         = ID_W'(idx);
                found             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rom_read_arbiter.sv
// rom_read_arbiter: round-robin arbiter and burst sequencer in front of a
// small combinational ROM.
//
// A requester posts a start address and a length (beats minus one). Once
// granted, the block walks consecutive ROM addresses (wrapping mod DEPTH) and
// returns one registered data beat per cycle, tagged with the owner's ID and
// a last-beat flag. One IDLE cycle separates consecutive bursts.
//
// Ports:
//   clk        in  1               rising-edge clock
//   rst_n      in  1               asynchronous active-low reset
//   req_valid  in  NUM_REQ         per-requester request pending
//   req_addr   in  NUM_REQ*ADDR_W  start address, requester i at [i*ADDR_W +: ADDR_W]
//   req_len    in  NUM_REQ*ADDR_W  beats minus one, same slicing
//   req_ready  out NUM_REQ         one-hot grant, accept on valid & ready
//   rom_addr   out ADDR_W          registered ROM address
//   rom_data   in  DATA_W          combinational ROM word for rom_addr
//   rsp_valid  out 1               data beat valid (no backpressure)
//   rsp_id     out ID_W            owner of the beat
//   rsp_data   out DATA_W          registered ROM word
//   rsp_last   out 1               final beat of the burst
//   busy       out 1               high while a burst is in progress
module rom_read_arbiter
    import rom_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = ROM_ADDR_W,
    parameter int unsigned DATA_W  = ROM_DATA_W,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*ADDR_W-1:0] req_len,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_data,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_last,
    output logic                      busy
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e              state_q,      state_d;
    logic [ADDR_W-1:0]   rom_addr_q,   rom_addr_d;
    logic [ADDR_W-1:0]   beat_cnt_q,   beat_cnt_d;
    logic [ID_W-1:0]     owner_q,      owner_d;
    logic [ID_W-1:0]     last_grant_q, last_grant_d;

    logic                rsp_valid_q,  rsp_valid_d;
    logic [ID_W-1:0]     rsp_id_q,     rsp_id_d;
    logic [DATA_W-1:0]   rsp_data_q,   rsp_data_d;
    logic                rsp_last_q,   rsp_last_d;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     grant_idx;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    // Grants are only offered in IDLE; rst_n gating keeps req_ready low for
    // the whole reset pulse, not just after the flops settle.
    always_comb begin
        req_ready = '0;
        if (rst_n && (state_q == IDLE)) begin
            req_ready = grant;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        rom_addr_d   = rom_addr_q;
        beat_cnt_d   = beat_cnt_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        rsp_valid_d  = 1'b0;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        rsp_last_d   = rsp_last_q;

        unique case (state_q)
            IDLE: begin
                // Accept edge: the winner's address and length are sampled
                // only here, so later changes on its inputs are ignored.
                if (|req_valid) begin
                    rom_addr_d   = req_addr[32'(grant_idx)*ADDR_W +: ADDR_W];
                    beat_cnt_d   = req_len[32'(grant_idx)*ADDR_W +: ADDR_W];
                    owner_d      = grant_idx;
                    last_grant_d = grant_idx;
                    state_d      = BURST;
                end
            end

            BURST: begin
                // Response stage registers the word for the current address.
                rsp_valid_d = 1'b1;
                rsp_data_d  = rom_data;
                rsp_id_d    = owner_q;
                rsp_last_d  = (beat_cnt_q == '0);

                if (beat_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    // ADDR_W-bit add wraps naturally at DEPTH.
                    rom_addr_d = rom_addr_q + ADDR_W'(1);
                    beat_cnt_d = beat_cnt_q - ADDR_W'(1);
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rom_addr_q   <= '0;
            beat_cnt_q   <= '0;
            owner_q      <= '0;
            // Requester 0 is first in line after reset.
            last_grant_q <= ID_W'(NUM_REQ - 1);
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_data_q   <= '0;
            rsp_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rom_addr_q   <= rom_addr_d;
            beat_cnt_q   <= beat_cnt_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_last_q   <= rsp_last_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rom_addr  = rom_addr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_last  = rsp_last_q;
    assign busy      = (state_q == BURST);

endmodule

// File: tb/tb_rom_read_arbiter.sv
// tb_rom_read_arbiter: self-checking bench for rom_read_arbiter.
// A combinational 8x8 ROM model sits next to the DUT. Expected beats are
// queued when a request is driven and popped by a monitor on the falling edge.
module tb_rom_read_arbiter;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned ADDR_W  = 3;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned ID_W    = 1;

    logic                      clk;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*ADDR_W-1:0] req_len;
    logic [NUM_REQ-1:0]        req_ready;
    logic [ADDR_W-1:0]         rom_addr;
    logic [DATA_W-1:0]         rom_data;
    logic                      rsp_valid;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_data;
    logic                      rsp_last;
    logic                      busy;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ID_W-1:0]   id;
        logic              last;
    } beat_t;

    beat_t sb[$];
    beat_t exp_b;
    int    total  = 0;
    int    passed = 0;

    function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
        case (a)
            3'd0:    return 8'hA0;
            3'd1:    return 8'hB1;
            3'd2:    return 8'h55;
            3'd3:    return 8'h54;
            3'd4:    return 8'hC4;
            3'd5:    return 8'hD5;
            3'd6:    return 8'hE6;
            default: return 8'hF7;
        endcase
    endfunction

    assign rom_data = rom_word(rom_addr);

    rom_read_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .ID_W    (ID_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .req_ready (req_ready),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_last  (rsp_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Scoreboard monitor: every response beat must match the queue head.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                $display("FAIL rsp_unexpected: got data=%h id=%0d last=%0b, required no beat",
                         rsp_data, rsp_id, rsp_last);
            end else begin
                exp_b = sb.pop_front();
                if ({rsp_data, rsp_id, rsp_last} !== {exp_b.data, exp_b.id, exp_b.last}) begin
                    $display("FAIL rsp_beat: got data=%h id=%0d last=%0b, required data=%h id=%0d last=%0b",
                             rsp_data, rsp_id, rsp_last, exp_b.data, exp_b.id, exp_b.last);
                end else begin
                    passed++;
                end
            end
        end
    end

    task automatic push_beat(input logic [ADDR_W-1:0] a, input int id, input bit last);
        beat_t b;
        b.data = rom_word(a);
        b.id   = ID_W'(id);
        b.last = last;
        sb.push_back(b);
    endtask

    task automatic set_req(input int i, input logic [ADDR_W-1:0] a,
                           input logic [ADDR_W-1:0] len);
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_len[i*ADDR_W +: ADDR_W]  = len;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        req_valid = 2'b11;
        rst_n     = 1'b0;
        #2;
        total++;
        if ({req_ready, busy, rsp_valid, rsp_last, rsp_id, rsp_data, rom_addr} !== '0) begin
            $display("FAIL reset_state: got ready=%b busy=%b rv=%b last=%b id=%0d data=%h addr=%0d, required all zero",
                     req_ready, busy, rsp_valid, rsp_last, rsp_id, rsp_data, rom_addr);
        end else passed++;
        req_valid = '0;
        do_reset();
    endtask

    task automatic test_single_beat;
        set_req(0, 3'd2, 3'd0);
        req_valid = 2'b01;
        #1;
        total++;
        if (req_ready !== 2'b01) begin
            $display("FAIL single_grant: got ready=%b, required 01", req_ready);
        end else passed++;
        push_beat(3'd2, 0, 1'b1);
        step();  // E0: accept
        req_valid = '0;
        total++;
        if ({busy, rsp_valid, req_ready, rom_addr} !== {1'b1, 1'b0, 2'b00, 3'd2}) begin
            $display("FAIL single_after_accept: got busy=%b rv=%b ready=%b addr=%0d, required 1 0 00 2",
                     busy, rsp_valid, req_ready, rom_addr);
        end else passed++;
        step();  // E1: beat
        total++;
        if ({rsp_valid, busy} !== 2'b10) begin
            $display("FAIL single_beat_timing: got rv=%b busy=%b, required 1 0", rsp_valid, busy);
        end else passed++;
        step();
        total++;
        if (rsp_valid !== 1'b0 || sb.size() != 0) begin
            $display("FAIL single_done: got rv=%b pending=%0d, required 0 0", rsp_valid, sb.size());
        end else passed++;
    endtask

    task automatic test_two_beat;
        logic [5:0] obs_busy;
        logic [5:0] obs_rv;
        set_req(1, 3'd2, 3'd1);
        req_valid = 2'b10;
        #1;
        total++;
        if (req_ready !== 2'b10) begin
            $display("FAIL two_grant: got ready=%b, required 10", req_ready);
        end else passed++;
        push_beat(3'd2, 1, 1'b0);
        push_beat(3'd3, 1, 1'b1);
        step();
        req_valid = '0;
        for (int k = 0; k < 6; k++) begin
            obs_busy[k] = busy;
            obs_rv[k]   = rsp_valid;
            step();
        end
        total++;
        if (obs_busy !== 6'b000011) begin
            $display("FAIL two_busy: got %b, required 000011", obs_busy);
        end else passed++;
        total++;
        if (obs_rv !== 6'b000110) begin
            $display("FAIL two_rsp_valid: got %b, required 000110", obs_rv);
        end else passed++;
    endtask

    task automatic test_wrap;
        logic [11:0] obs_busy;
        logic [11:0] obs_rv;
        set_req(0, 3'd6, 3'd7);
        req_valid = 2'b01;
        #1;
        total++;
        if (req_ready !== 2'b01) begin
            $display("FAIL wrap_grant: got ready=%b, required 01", req_ready);
        end else passed++;
        for (int i = 0; i < 8; i++) begin
            push_beat(3'(6 + i), 0, (i == 7));
        end
        step();
        req_valid = '0;
        // Changing the inputs mid-burst must have no effect.
        set_req(0, 3'd1, 3'd0);
        for (int k = 0; k < 12; k++) begin
            obs_busy[k] = busy;
            obs_rv[k]   = rsp_valid;
            step();
        end
        total++;
        if (obs_busy !== 12'h0FF) begin
            $display("FAIL wrap_busy: got %h, required 0ff", obs_busy);
        end else passed++;
        total++;
        if (obs_rv !== 12'h1FE || sb.size() != 0) begin
            $display("FAIL wrap_rsp_valid: got %h pending=%0d, required 1fe 0", obs_rv, sb.size());
        end else passed++;
    endtask

    task automatic test_alternate;
        logic [NUM_REQ-1:0] exp_ready;
        do_reset();
        set_req(0, 3'd3, 3'd0);
        set_req(1, 3'd5, 3'd0);
        req_valid = 2'b11;
        #1;
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 1)      exp_ready = 2'b00;
            else if (k % 4 == 0) exp_ready = 2'b01;
            else                 exp_ready = 2'b10;
            total++;
            if ({req_ready, busy} !== {exp_ready, 1'(k % 2)}) begin
                $display("FAIL alt_cycle%0d: got ready=%b busy=%b, required ready=%b busy=%0d",
                         k, req_ready, busy, exp_ready, k % 2);
            end else passed++;
            if (k % 2 == 0) begin
                if (k % 4 == 0) push_beat(3'd3, 0, 1'b1);
                else            push_beat(3'd5, 1, 1'b1);
            end
            if (k == 7) req_valid = '0;
            step();
        end
        step();
        total++;
        if ({rsp_valid, req_ready} !== 3'b000 || sb.size() != 0) begin
            $display("FAIL alt_done: got rv=%b ready=%b pending=%0d, required 0 00 0",
                     rsp_valid, req_ready, sb.size());
        end else passed++;
    endtask

    task automatic test_reset_mid_burst;
        logic seen;
        set_req(0, 3'd0, 3'd7);
        req_valid = 2'b01;
        #1;
        push_beat(3'd0, 0, 1'b0);
        push_beat(3'd1, 0, 1'b0);
        step();  // E0
        req_valid = '0;
        step();  // E1: beat 1
        step();  // E2: beat 2
        step();  // E3: beat 3 on the bus
        total++;
        if (rsp_valid !== 1'b1) begin
            $display("FAIL mid_third_beat: got rv=%b, required 1", rsp_valid);
        end else passed++;
        req_valid = 2'b11;
        rst_n     = 1'b0;
        #1;
        total++;
        if ({rsp_valid, busy, req_ready} !== 4'b0000) begin
            $display("FAIL mid_abort: got rv=%b busy=%b ready=%b, required 0 0 00",
                     rsp_valid, busy, req_ready);
        end else passed++;
        seen = 1'b0;
        repeat (3) begin
            step();
            seen = seen | rsp_valid | rsp_last;
        end
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            step();
            seen = seen | rsp_valid | rsp_last;
        end
        total++;
        if (seen !== 1'b0 || sb.size() != 0) begin
            $display("FAIL mid_quiet: got activity=%b pending=%0d, required 0 0", seen, sb.size());
        end else passed++;
        set_req(0, 3'd3, 3'd0);
        set_req(1, 3'd5, 3'd0);
        req_valid = 2'b11;
        #1;
        total++;
        if (req_ready !== 2'b01) begin
            $display("FAIL mid_cold_grant: got ready=%b, required 01", req_ready);
        end else passed++;
        push_beat(3'd3, 0, 1'b1);
        step();
        req_valid = '0;
        step();
        total++;
        if (rsp_valid !== 1'b1) begin
            $display("FAIL mid_cold_beat: got rv=%b, required 1", rsp_valid);
        end else passed++;
        step();
        total++;
        if (sb.size() != 0) begin
            $display("FAIL mid_cold_pending: got %0d beats outstanding, required 0", sb.size());
        end else passed++;
    endtask

    initial begin
        rst_n     = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_len   = '0;
        #1;
        test_reset();
        test_single_beat();
        test_two_beat();
        test_wrap();
        test_alternate();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
